mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 172 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: an instruction-fetch port (IF) and a load/store
// port (LS) share one single-cycle memory. Each access takes a grant cycle in
// IDLE and one ACC cycle on the memory; the response is registered and pulses
// rvalid on the requester's port in the cycle after ACC.
module mem_arbiter (
    input  logic        clk,
    input  logic        rst_n,

    // Instruction-fetch port
    input  logic        if_req,
    input  logic [5:0]  if_addr,
    output logic        if_gnt,
    output logic [31:0] if_rdata,
    output logic        if_rvalid,

    // Load/store port
    input  logic        ls_req,
    input  logic        ls_we,
    input  logic [5:0]  ls_addr,
    input  logic [31:0] ls_wdata,
    input  logic [2:0]  ls_f3,
    output logic        ls_gnt,
    output logic [31:0] ls_rdata,
    output logic        ls_rvalid,

    // Memory side
    output logic        mem_read,
    output logic        mem_write,
    output logic [5:0]  mem_addr,
    output logic [31:0] mem_wdata,
    output logic [2:0]  mem_f3,
    input  logic [31:0] mem_rdata,

    output logic        busy
);

    typedef enum logic [0:0] {
        StIdle,
        StAcc
    } state_e;

    // funct3 for a full-word access, used for every fetch
    localparam logic [2:0] F3Word = 3'b010;
    // Starvation count at which a waiting fetch beats a competing load/store
    localparam logic [1:0] StarveMax = 2'd2;

    state_e      state_q, state_d;
    logic [1:0]  starve_q, starve_d;

    // Fields latched on the granting edge
    logic        owner_ls_q;
    logic        we_q;
    logic [5:0]  addr_q;
    logic [31:0] wdata_q;
    logic [2:0]  f3_q;

    // Registered responses
    logic        if_rvalid_q, ls_rvalid_q;
    logic [31:0] if_rdata_q, ls_rdata_q;

    logic        idle;
    logic        if_win;
    logic        any_gnt;

    assign idle = (state_q == StIdle);

    // LS has priority on a tie unless IF has already lost twice in a row.
    assign if_win  = if_req & (~ls_req | (starve_q == StarveMax));
    assign if_gnt  = idle & if_win;
    assign ls_gnt  = idle & ls_req & ~if_win;
    assign any_gnt = if_gnt | ls_gnt;

    // Next-state logic: one ACC cycle per grant, then straight back to IDLE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (any_gnt) begin
                    state_d = StAcc;
                end
            end
            StAcc: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Starvation counter: only evaluated in IDLE, holds its value across ACC.
    always_comb begin
        starve_d = starve_q;
        if (idle) begin
            if (!if_req || if_gnt) begin
                starve_d = 2'd0;
            end else if (ls_gnt && (starve_q != StarveMax)) begin
                starve_d = starve_q + 2'd1;
            end
        end
    end

    // State and fairness registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            starve_q <= 2'd0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
        end
    end

    // Capture the winning request; these also drive mem_* and hold in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_ls_q <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= 6'd0;
            wdata_q    <= 32'd0;
            f3_q       <= 3'd0;
        end else if (if_gnt) begin
            owner_ls_q <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= if_addr;
            wdata_q    <= 32'd0;
            f3_q       <= F3Word;
        end else if (ls_gnt) begin
            owner_ls_q <= 1'b1;
            we_q       <= ls_we;
            addr_q     <= ls_addr;
            wdata_q    <= ls_wdata;
            f3_q       <= ls_f3;
        end
    end

    // Register the response at the end of ACC into the owner's port only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_rvalid_q <= 1'b0;
            ls_rvalid_q <= 1'b0;
            if_rdata_q  <= 32'd0;
            ls_rdata_q  <= 32'd0;
        end else begin
            if_rvalid_q <= 1'b0;
            ls_rvalid_q <= 1'b0;
            if (state_q == StAcc) begin
                if (owner_ls_q) begin
                    ls_rvalid_q <= 1'b1;
                    // A store returns zero as its completion data
                    ls_rdata_q  <= we_q ? 32'd0 : mem_rdata;
                end else begin
                    if_rvalid_q <= 1'b1;
                    if_rdata_q  <= mem_rdata;
                end
            end
        end
    end

    assign busy      = (state_q == StAcc);
    assign mem_read  = busy & ~we_q;
    assign mem_write = busy & we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_f3    = f3_q;

    assign if_rvalid = if_rvalid_q;
    assign if_rdata  = if_rdata_q;
    assign ls_rvalid = ls_rvalid_q;
    assign ls_rdata  = ls_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios with literal expectations plus a
// randomized phase, all cross-checked every cycle by a transaction-level model.
module tb_mem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        if_req;
    logic [5:0]  if_addr;
    logic        if_gnt;
    logic [31:0] if_rdata;
    logic        if_rvalid;
    logic        ls_req;
    logic        ls_we;
    logic [5:0]  ls_addr;
    logic [31:0] ls_wdata;
    logic [2:0]  ls_f3;
    logic        ls_gnt;
    logic [31:0] ls_rdata;
    logic        ls_rvalid;
    logic        mem_read;
    logic        mem_write;
    logic [5:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [2:0]  mem_f3;
    logic [31:0] mem_rdata;
    logic        busy;

    int checks = 0;
    int errors = 0;

    mem_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rdata  (if_rdata),
        .if_rvalid (if_rvalid),
        .ls_req    (ls_req),
        .ls_we     (ls_we),
        .ls_addr   (ls_addr),
        .ls_wdata  (ls_wdata),
        .ls_f3     (ls_f3),
        .ls_gnt    (ls_gnt),
        .ls_rdata  (ls_rdata),
        .ls_rvalid (ls_rvalid),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_f3    (mem_f3),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %h required %h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Transaction-level model: a granted access sits in acc_q for one
    // cycle, then its response sits in rsp_q for one cycle.
    // ------------------------------------------------------------------
    typedef struct {
        bit          is_ls;
        bit          we;
        logic [5:0]  addr;
        logic [31:0] wdata;
        logic [2:0]  f3;
    } txn_t;

    txn_t        acc_q[$];
    txn_t        rsp_q[$];
    int          m_starve;
    logic [5:0]  m_addr;
    logic [31:0] m_wdata;
    logic [2:0]  m_f3;
    logic [31:0] m_if_rdata;
    logic [31:0] m_ls_rdata;

    always @(negedge clk) begin
        bit   idle;
        bit   e_if_gnt;
        bit   e_ls_gnt;
        bit   in_acc;
        txn_t t;
        if (!rst_n) begin
            acc_q.delete();
            rsp_q.delete();
            m_starve   = 0;
            m_addr     = '0;
            m_wdata    = '0;
            m_f3       = '0;
            m_if_rdata = '0;
            m_ls_rdata = '0;
            chk("rst_outputs", {8'd0, busy, mem_read, mem_write, if_rvalid, ls_rvalid,
                                mem_f3, mem_addr, 12'd0}, 32'd0);
            chk("rst_mem_wdata", mem_wdata, 32'd0);
            chk("rst_if_rdata", if_rdata, 32'd0);
            chk("rst_ls_rdata", ls_rdata, 32'd0);
        end else begin
            idle     = (acc_q.size() == 0);
            e_if_gnt = idle && if_req && (!ls_req || m_starve == 2);
            e_ls_gnt = idle && ls_req && !e_if_gnt;
            in_acc   = !idle;
            chk("m_if_gnt", 32'(if_gnt), 32'(e_if_gnt));
            chk("m_ls_gnt", 32'(ls_gnt), 32'(e_ls_gnt));
            chk("m_busy", 32'(busy), 32'(in_acc));
            chk("m_mem_read", 32'(mem_read), 32'(in_acc && !acc_q[0].we));
            chk("m_mem_write", 32'(mem_write), 32'(in_acc && acc_q[0].we));
            chk("m_mem_addr", 32'(mem_addr), 32'(m_addr));
            chk("m_mem_wdata", mem_wdata, m_wdata);
            chk("m_mem_f3", 32'(mem_f3), 32'(m_f3));
            chk("m_if_rvalid", 32'(if_rvalid), 32'(rsp_q.size() != 0 && !rsp_q[0].is_ls));
            chk("m_ls_rvalid", 32'(ls_rvalid), 32'(rsp_q.size() != 0 && rsp_q[0].is_ls));
            chk("m_if_rdata", if_rdata, m_if_rdata);
            chk("m_ls_rdata", ls_rdata, m_ls_rdata);

            // Advance the model to what the next clock edge produces.
            rsp_q.delete();
            if (in_acc) begin
                t = acc_q.pop_front();
                if (t.is_ls) m_ls_rdata = t.we ? 32'd0 : mem_rdata;
                else         m_if_rdata = mem_rdata;
                rsp_q.push_back(t);
            end
            if (idle) begin
                if (e_if_gnt || !if_req) m_starve = 0;
                else if (e_ls_gnt && m_starve < 2) m_starve = m_starve + 1;
            end
            if (e_if_gnt) begin
                t = '{is_ls: 1'b0, we: 1'b0, addr: if_addr, wdata: 32'd0, f3: 3'b010};
                acc_q.push_back(t);
            end else if (e_ls_gnt) begin
                t = '{is_ls: 1'b1, we: ls_we, addr: ls_addr, wdata: ls_wdata, f3: ls_f3};
                acc_q.push_back(t);
            end
            if (e_if_gnt || e_ls_gnt) begin
                m_addr  = t.addr;
                m_wdata = t.wdata;
                m_f3    = t.f3;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        if_req    = 1'b0;
        if_addr   = '0;
        ls_req    = 1'b0;
        ls_we     = 1'b0;
        ls_addr   = '0;
        ls_wdata  = '0;
        ls_f3     = '0;
        mem_rdata = '0;

        // Reset state
        @(negedge clk);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_if_gnt", 32'(if_gnt), 32'd0);

        // Single fetch right after reset release
        step();
        rst_n     = 1'b1;
        if_req    = 1'b1;
        if_addr   = 6'd5;
        mem_rdata = 32'hDEADBEEF;
        @(negedge clk);
        chk("fetch_gnt", 32'(if_gnt), 32'd1);
        chk("fetch_no_ls_gnt", 32'(ls_gnt), 32'd0);
        step();
        if_req = 1'b0;
        @(negedge clk);
        chk("fetch_mem_read", 32'(mem_read), 32'd1);
        chk("fetch_mem_addr", 32'(mem_addr), 32'd5);
        chk("fetch_mem_f3", 32'(mem_f3), 32'd2);
        @(negedge clk);
        chk("fetch_rvalid", 32'(if_rvalid), 32'd1);
        chk("fetch_rdata", if_rdata, 32'hDEADBEEF);

        // Single store
        step();
        ls_req   = 1'b1;
        ls_we    = 1'b1;
        ls_addr  = 6'd9;
        ls_wdata = 32'h12345678;
        ls_f3    = 3'b000;
        @(negedge clk);
        chk("store_gnt", 32'(ls_gnt), 32'd1);
        step();
        ls_req = 1'b0;
        @(negedge clk);
        chk("store_mem_write", 32'(mem_write), 32'd1);
        chk("store_mem_read", 32'(mem_read), 32'd0);
        chk("store_mem_addr", 32'(mem_addr), 32'd9);
        chk("store_mem_wdata", mem_wdata, 32'h12345678);
        chk("store_mem_f3", 32'(mem_f3), 32'd0);
        @(negedge clk);
        chk("store_rvalid", 32'(ls_rvalid), 32'd1);
        chk("store_rdata", ls_rdata, 32'd0);
        chk("store_write_done", 32'(mem_write), 32'd0);

        // Both requesters held: LS, LS, IF repeating
        step();
        if_req = 1'b1;
        if_addr = 6'd1;
        ls_req = 1'b1;
        ls_we  = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (i % 2 == 0) begin
                chk("seq_if_gnt", 32'(if_gnt), 32'((i / 2) % 3 == 2));
                chk("seq_ls_gnt", 32'(ls_gnt), 32'((i / 2) % 3 != 2));
            end else begin
                chk("seq_busy", 32'(busy), 32'd1);
            end
        end
        step();
        if_req = 1'b0;
        ls_req = 1'b0;

        // Reset during an LS load aborts it
        ls_req    = 1'b1;
        ls_we     = 1'b0;
        ls_addr   = 6'd3;
        mem_rdata = 32'hCAFEF00D;
        step();
        ls_req = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_mem_read", 32'(mem_read), 32'd0);
        chk("abort_mem_addr", 32'(mem_addr), 32'd0);
        chk("abort_if_rdata", if_rdata, 32'd0);
        step();
        rst_n    = 1'b1;
        ls_req   = 1'b1;
        ls_we    = 1'b1;
        ls_addr  = 6'd4;
        ls_wdata = 32'h0000_00A5;
        @(negedge clk);
        chk("post_rst_gnt", 32'(ls_gnt), 32'd1);
        chk("post_rst_no_rvalid", 32'(ls_rvalid), 32'd0);
        step();
        ls_req = 1'b0;
        @(negedge clk);
        chk("post_rst_write", 32'(mem_write), 32'd1);
        chk("post_rst_no_rvalid2", 32'(ls_rvalid), 32'd0);
        @(negedge clk);
        chk("post_rst_ack", 32'(ls_rvalid), 32'd1);

        // LS request raised while busy waits for the next IDLE
        step();
        if_req  = 1'b1;
        if_addr = 6'd7;
        @(negedge clk);
        chk("busy_if_gnt", 32'(if_gnt), 32'd1);
        step();
        if_req  = 1'b0;
        ls_req  = 1'b1;
        ls_we   = 1'b0;
        ls_addr = 6'd10;
        @(negedge clk);
        chk("busy_hold_gnt", 32'(ls_gnt), 32'd0);
        chk("busy_flag", 32'(busy), 32'd1);
        @(negedge clk);
        chk("busy_then_gnt", 32'(ls_gnt), 32'd1);
        chk("busy_if_rvalid", 32'(if_rvalid), 32'd1);
        step();
        ls_req = 1'b0;

        // Randomized traffic, checked by the model every cycle
        for (int n = 0; n < 4000; n++) begin
            step();
            if_req    = ($urandom_range(0, 9) < 6);
            ls_req    = ($urandom_range(0, 9) < 6);
            if_addr   = 6'($urandom);
            ls_we     = 1'($urandom);
            ls_addr   = 6'($urandom);
            ls_wdata  = $urandom;
            ls_f3     = 3'($urandom);
            mem_rdata = $urandom;
        end
        step();
        if_req = 1'b0;
        ls_req = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
